// File: rtl/rf_debug_port.sv
// Debug access port for a 32x32 register file: streams out all registers in
// address order (dump) or writes registers 1..31 from an input stream (load).
module rf_debug_port (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmd_valid,
  input  logic        cmd_op,
  output logic        cmd_ready,
  output logic        dout_valid,
  input  logic        dout_ready,
  output logic [31:0] dout_data,
  output logic [4:0]  dout_addr,
  input  logic        din_valid,
  output logic        din_ready,
  input  logic [31:0] din_data,
  output logic [4:0]  rf_read_addr_s,
  output logic [4:0]  rf_read_addr_t,
  input  logic [31:0] rf_outA,
  input  logic [31:0] rf_outB,
  output logic [4:0]  rf_write_addr,
  output logic [31:0] rf_write_data,
  output logic        rf_write_en,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD     = 3'd1,
    SEND_A = 3'd2,
    SEND_B = 3'd3,
    LOAD   = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t      state_reg, state_next;
  logic [3:0]  pair_reg, pair_next, pair_inc;
  logic [4:0]  widx_reg, widx_next;
  logic [31:0] buf_a_reg, buf_b_reg;
  logic [4:0]  rd_s_reg, rd_s_next;
  logic [4:0]  rd_t_reg, rd_t_next;
  logic        wr_en_reg, wr_en_next;
  logic [4:0]  wr_addr_reg, wr_addr_next;
  logic [31:0] wr_data_reg, wr_data_next;

  assign pair_inc = pair_reg + 4'd1;

  always_comb begin
    state_next   = state_reg;
    pair_next    = pair_reg;
    widx_next    = widx_reg;
    rd_s_next    = rd_s_reg;
    rd_t_next    = rd_t_reg;
    wr_en_next   = 1'b0;
    wr_addr_next = wr_addr_reg;
    wr_data_next = wr_data_reg;
    cmd_ready    = 1'b0;
    busy         = 1'b1;
    done         = 1'b0;
    din_ready    = 1'b0;
    dout_valid   = 1'b0;
    dout_data    = 32'd0;
    dout_addr    = 5'd0;
    case (state_reg)
      IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) begin
          if (cmd_op) begin
            state_next = LOAD;
            widx_next  = 5'd1;
          end else begin
            state_next = RD;
            pair_next  = 4'd0;
            rd_s_next  = 5'd0;
            rd_t_next  = 5'd1;
          end
        end
      end
      RD: state_next = SEND_A;
      SEND_A: begin
        dout_valid = 1'b1;
        dout_data  = buf_a_reg;
        dout_addr  = {pair_reg, 1'b0};
        if (dout_ready) state_next = SEND_B;
      end
      SEND_B: begin
        dout_valid = 1'b1;
        dout_data  = buf_b_reg;
        dout_addr  = {pair_reg, 1'b1};
        if (dout_ready) begin
          if (pair_reg == 4'd15) begin
            state_next = DONE;
            pair_next  = 4'd0;
          end else begin
            // Read addresses for the next pair are registered on entry to RD
            state_next = RD;
            pair_next  = pair_inc;
            rd_s_next  = {pair_inc, 1'b0};
            rd_t_next  = {pair_inc, 1'b1};
          end
        end
      end
      LOAD: begin
        din_ready = 1'b1;
        if (din_valid) begin
          wr_en_next   = 1'b1;
          wr_addr_next = widx_reg;
          wr_data_next = din_data;
          if (widx_reg == 5'd31) begin
            state_next = DONE;
            widx_next  = 5'd1;
          end else begin
            widx_next = widx_reg + 5'd1;
          end
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg   <= IDLE;
      pair_reg    <= 4'd0;
      widx_reg    <= 5'd1;
      buf_a_reg   <= 32'd0;
      buf_b_reg   <= 32'd0;
      rd_s_reg    <= 5'd0;
      rd_t_reg    <= 5'd0;
      wr_en_reg   <= 1'b0;
      wr_addr_reg <= 5'd0;
      wr_data_reg <= 32'd0;
    end else begin
      state_reg   <= state_next;
      pair_reg    <= pair_next;
      widx_reg    <= widx_next;
      rd_s_reg    <= rd_s_next;
      rd_t_reg    <= rd_t_next;
      wr_en_reg   <= wr_en_next;
      wr_addr_reg <= wr_addr_next;
      wr_data_reg <= wr_data_next;
      // Register file data settles on the falling edge inside RD
      if (state_reg == RD) begin
        buf_a_reg <= rf_outA;
        buf_b_reg <= rf_outB;
      end
    end
  end

  assign rf_read_addr_s = rd_s_reg;
  assign rf_read_addr_t = rd_t_reg;
  assign rf_write_en    = wr_en_reg;
  assign rf_write_addr  = wr_addr_reg;
  assign rf_write_data  = wr_data_reg;

endmodule

// File: tb/tb_rf_debug_port.sv
// Bench for rf_debug_port: register-file model, expected-contents array and
// randomized dump/load traffic with stall, back-to-back and reset cases.
module tb_rf_debug_port;

  logic        clock = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_op, cmd_ready;
  logic        dout_valid, dout_ready;
  logic [31:0] dout_data;
  logic [4:0]  dout_addr;
  logic        din_valid, din_ready;
  logic [31:0] din_data;
  logic [4:0]  rf_read_addr_s, rf_read_addr_t;
  logic [31:0] rf_outA, rf_outB;
  logic [4:0]  rf_write_addr;
  logic [31:0] rf_write_data;
  logic        rf_write_en;
  logic        busy, done;

  rf_debug_port dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_ready(cmd_ready),
    .dout_valid(dout_valid), .dout_ready(dout_ready),
    .dout_data(dout_data), .dout_addr(dout_addr),
    .din_valid(din_valid), .din_ready(din_ready), .din_data(din_data),
    .rf_read_addr_s(rf_read_addr_s), .rf_read_addr_t(rf_read_addr_t),
    .rf_outA(rf_outA), .rf_outB(rf_outB),
    .rf_write_addr(rf_write_addr), .rf_write_data(rf_write_data),
    .rf_write_en(rf_write_en), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  // Register file: reads update on the falling edge, writes on the rising edge
  logic [31:0] rf_mem [32];
  always @(negedge clock) begin
    rf_outA = rf_mem[rf_read_addr_s];
    rf_outB = rf_mem[rf_read_addr_t];
  end
  always @(posedge clock) if (rf_write_en) rf_mem[rf_write_addr] = rf_write_data;

  // Expected register contents and the values fed to a load
  logic [31:0] ref_mem [32];
  logic [31:0] load_vals [32];

  typedef struct { logic [4:0] a; logic [31:0] d; } wr_t;
  wr_t wr_log[$];
  int  accept_cnt = 0;
  always @(posedge clock) begin
    if (rf_write_en) wr_log.push_back('{rf_write_addr, rf_write_data});
    if (cmd_valid && cmd_ready && !reset) accept_cnt++;
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_cmd_ready();
    int n = 0;
    while (!cmd_ready && n < 200) begin
      tick();
      n++;
    end
    check("cmd_ready_wait", 32'(cmd_ready), 32'd1);
  endtask

  // mode 0: ready held high, 1: ready toggles, 2: random ready.
  // stop_addr >= 0 applies reset while that dump beat is presented.
  task automatic run_dump(input int mode, input string name, input int stop_addr);
    logic [31:0] prev_d;
    logic [4:0]  prev_a;
    logic        prev_stall;
    int b, edges, guard, wr_seen;
    wait_cmd_ready();
    cmd_op = 1'b0;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    b = 0; edges = 0; guard = 0; wr_seen = 0; prev_stall = 1'b0;
    prev_d = '0; prev_a = '0;
    while (b < 32 && guard < 2000) begin
      if (prev_stall) begin
        check("stall_valid", 32'(dout_valid), 32'd1);
        check("stall_data", dout_data, prev_d);
        check("stall_addr", 32'(dout_addr), 32'(prev_a));
      end
      if (rf_write_en) wr_seen++;
      if (stop_addr >= 0 && dout_valid && dout_addr == 5'(stop_addr)) begin
        reset = 1'b1;
        tick();
        check("rst_dout_valid", 32'(dout_valid), 32'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_wr_en", 32'(rf_write_en), 32'd0);
        reset = 1'b0;
        tick();
        check("post_rst_dout_valid", 32'(dout_valid), 32'd0);
        $display("dump %s: reset applied at addr %0d after %0d beats", name, stop_addr, b);
        return;
      end
      case (mode)
        0:       dout_ready = 1'b1;
        1:       dout_ready = (edges % 2 == 0);
        default: dout_ready = 1'($urandom_range(0, 1));
      endcase
      if (dout_valid && dout_ready) begin
        check("beat_addr", 32'(dout_addr), 32'(b));
        check("beat_data", dout_data, ref_mem[b]);
        b++;
      end
      prev_stall = dout_valid && !dout_ready;
      prev_d = dout_data;
      prev_a = dout_addr;
      tick();
      edges++;
      guard++;
    end
    dout_ready = 1'b0;
    while (!done && guard < 2100) begin
      if (rf_write_en) wr_seen++;
      tick();
      edges++;
      guard++;
    end
    check("dump_beats", 32'(b), 32'd32);
    check("dump_done", 32'(done), 32'd1);
    check("dump_no_write", 32'(wr_seen), 32'd0);
    check("dump_dout_valid_done", 32'(dout_valid), 32'd0);
    if (mode == 0) check("dump_latency", 32'(edges), 32'd48);
    tick();
    check("done_pulse", 32'(done), 32'd0);
    check("idle_after_done", 32'(cmd_ready), 32'd1);
    $display("dump %s: beats=%0d cycles=%0d", name, b, edges);
  endtask

  task automatic run_load(input string name, input int gap_max, input logic hold_cmd);
    int guard;
    wr_log.delete();
    accept_cnt = 0;
    wait_cmd_ready();
    cmd_op = 1'b1;
    cmd_valid = 1'b1;
    tick();
    if (!hold_cmd) cmd_valid = 1'b0;
    for (int n = 1; n < 32; n++) begin
      din_valid = 1'b0;
      repeat ($urandom_range(0, gap_max)) tick();
      din_valid = 1'b1;
      din_data = load_vals[n];
      guard = 0;
      while (!din_ready && guard < 100) begin
        tick();
        guard++;
      end
      check("din_ready", 32'(din_ready), 32'd1);
      tick();
      ref_mem[n] = load_vals[n];
    end
    din_valid = 1'b0;
    guard = 0;
    while (!done && guard < 100) begin
      tick();
      guard++;
    end
    check("load_done", 32'(done), 32'd1);
    check("load_din_ready_done", 32'(din_ready), 32'd0);
    check("load_last_wr_en", 32'(rf_write_en), 32'd1);
    if (hold_cmd) check("hold_single_accept", 32'(accept_cnt), 32'd1);
    tick();
    check("load_done_pulse", 32'(done), 32'd0);
    check("load_idle", 32'(cmd_ready), 32'd1);
    check("load_wr_en_off", 32'(rf_write_en), 32'd0);
    check("load_write_count", 32'(wr_log.size()), 32'd31);
    for (int i = 0; i < wr_log.size() && i < 31; i++) begin
      check("load_write_addr", 32'(wr_log[i].a), 32'(i + 1));
      check("load_write_data", wr_log[i].d, load_vals[i + 1]);
    end
    $display("load %s: writes=%0d accepts=%0d", name, wr_log.size(), accept_cnt);
  endtask

  initial begin
    reset = 1'b1;
    cmd_valid = 1'b0; cmd_op = 1'b0;
    dout_ready = 1'b0; din_valid = 1'b0; din_data = '0;
    for (int i = 0; i < 32; i++) begin
      rf_mem[i] = 32'hA000_0000 + 32'(i);
      ref_mem[i] = 32'hA000_0000 + 32'(i);
    end
    repeat (3) tick();
    check("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_dout_valid", 32'(dout_valid), 32'd0);
    check("reset_din_ready", 32'(din_ready), 32'd0);
    check("reset_wr_en", 32'(rf_write_en), 32'd0);
    check("reset_rd_s", 32'(rf_read_addr_s), 32'd0);
    check("reset_rd_t", 32'(rf_read_addr_t), 32'd0);
    check("reset_dout_data", dout_data, 32'd0);
    reset = 1'b0;
    tick();

    run_dump(0, "preload", -1);
    run_dump(1, "toggle_ready", -1);
    run_dump(0, "reset_pair7", 15);
    run_dump(0, "after_reset", -1);

    for (int i = 0; i < 32; i++) begin
      rf_mem[i] = 32'd0;
      ref_mem[i] = 32'd0;
      load_vals[i] = 32'h5555_0000 + 32'(i);
    end
    run_load("pattern", 0, 1'b0);
    run_dump(0, "after_pattern_load", -1);

    for (int i = 0; i < 32; i++) load_vals[i] = $urandom;
    run_load("random_hold_cmd", 3, 1'b1);
    cmd_op = 1'b0;
    run_dump(2, "back_to_back", -1);
    check("hold_next_accept", 32'(accept_cnt), 32'd2);

    for (int k = 0; k < 3; k++) run_dump(2, "random_ready", -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
